// File: rtl/conv_seq_same.sv
// Convolution sequencer: walks full-convolution outputs, issues X/Y addresses with MAC control, writes results.
// Optional `CONV_SAME_MODE_EN keeps only the centred size_x outputs starting at init_i; default is full mode.
module conv_seq_same (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [4:0] size_x_i,
  input  logic [4:0] size_y_i,
  input  logic [5:0] init_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] memx_addr_o,
  output logic [4:0] memy_addr_o,
  output logic       mac_en_o,
  output logic       mac_clr_o,
  output logic       res_we_o,
  output logic [5:0] res_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [5:0] j_q, j_d;
  logic [5:0] sx_q, sy_q, len_q;
  logic [5:0] sx_c, sy_c, len_c;

  logic       busy_d, done_d, mac_en_d, mac_clr_d, res_we_d;
  logic [4:0] memx_d, memy_d;
  logic [5:0] res_addr_d;
  logic       in_window;

  // First term index for output n (requires sx >= 1).
  function automatic logic [5:0] jlo_f(input logic [5:0] n, input logic [5:0] sx);
    return (n >= sx - 6'd1) ? n - (sx - 6'd1) : 6'd0;
  endfunction

  function automatic logic [5:0] jhi_f(input logic [5:0] n, input logic [5:0] sy);
    return (n < sy - 6'd1) ? n : sy - 6'd1;
  endfunction

  // During LOAD the job parameters come straight from the ports; afterwards from the latched copies.
  assign sx_c  = (state_q == S_LOAD) ? {1'b0, size_x_i} : sx_q;
  assign sy_c  = (state_q == S_LOAD) ? {1'b0, size_y_i} : sy_q;
  assign len_c = sx_c + sy_c - 6'd1;

`ifdef CONV_SAME_MODE_EN
  logic [5:0] init_q, init_c;
  logic [6:0] win_lo, win_hi, n_ext;

  assign init_c = (state_q == S_LOAD) ? init_i : init_q;
  assign n_ext  = {1'b0, n_d};
  assign win_lo = {1'b0, init_c};
  assign win_hi = {1'b0, init_c} + {1'b0, sx_c};
  assign in_window = (n_ext >= win_lo) && (n_ext < win_hi);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      init_q <= '0;
    end else if (state_q == S_LOAD) begin
      init_q <= init_i;
    end
  end
`else
  logic init_unused;
  assign init_unused = ^init_i;
  assign in_window   = 1'b1;
`endif

  // NOTE: every variable assigned here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          n_d     = '0;
          j_d     = '0;
        end
      end
      S_LOAD: begin
        state_d = (sx_c == 6'd0 || sy_c == 6'd0) ? S_DONE : S_MAC;
        n_d     = '0;
        j_d     = '0;
      end
      S_MAC: begin
        if (j_q == jhi_f(n_q, sy_q)) begin
          state_d = S_WRITE;
        end else begin
          j_d = j_q + 6'd1;
        end
      end
      S_WRITE: begin
        n_d = n_q + 6'd1;
        if (n_q == len_q - 6'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MAC;
          j_d     = jlo_f(n_q + 6'd1, sx_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        n_d     = '0;
        j_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        n_d     = '0;
        j_d     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies line up with the state they describe.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    mac_en_d   = (state_d == S_MAC);
    mac_clr_d  = 1'b0;
    memx_d     = '0;
    memy_d     = '0;
    res_we_d   = 1'b0;
    res_addr_d = '0;
    if (mac_en_d) begin
      memy_d    = j_d[4:0];
      memx_d    = n_d[4:0] - j_d[4:0];
      mac_clr_d = (j_d == jlo_f(n_d, sx_c));
    end
    if (state_d == S_WRITE && in_window) begin
      res_we_d = 1'b1;
`ifdef CONV_SAME_MODE_EN
      res_addr_d = n_d - init_c;
`else
      res_addr_d = n_d;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      j_q         <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      len_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mac_en_o    <= 1'b0;
      mac_clr_o   <= 1'b0;
      memx_addr_o <= '0;
      memy_addr_o <= '0;
      res_we_o    <= 1'b0;
      res_addr_o  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      mac_en_o    <= mac_en_d;
      mac_clr_o   <= mac_clr_d;
      memx_addr_o <= memx_d;
      memy_addr_o <= memy_d;
      res_we_o    <= res_we_d;
      res_addr_o  <= res_addr_d;
      if (state_q == S_LOAD) begin
        sx_q  <= sx_c;
        sy_q  <= sy_c;
        len_q <= len_c;
      end
    end
  end

endmodule

// File: tb/tb_conv_seq_same.sv
// Self-checking bench for conv_seq_same: per-cycle comparison against a pair-enumeration model of the convolution schedule.
module tb_conv_seq_same;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [4:0] size_x = '0;
  logic [4:0] size_y = '0;
  logic [5:0] init = '0;
  logic       busy, done, mac_en, mac_clr, res_we;
  logic [4:0] memx_addr, memy_addr;
  logic [5:0] res_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit busy;
    bit done;
    bit mac_en;
    bit mac_clr;
    bit we;
    int x;
    int y;
    int addr;
  } exp_t;

  exp_t q[$];

  conv_seq_same dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .size_x_i   (size_x),
    .size_y_i   (size_y),
    .init_i     (init),
    .busy_o     (busy),
    .done_o     (done),
    .memx_addr_o(memx_addr),
    .memy_addr_o(memy_addr),
    .mac_en_o   (mac_en),
    .mac_clr_o  (mac_clr),
    .res_we_o   (res_we),
    .res_addr_o (res_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".mac_en"}, mac_en, 0);
    check({tag, ".mac_clr"}, mac_clr, 0);
    check({tag, ".memx"}, memx_addr, 0);
    check({tag, ".memy"}, memy_addr, 0);
    check({tag, ".we"}, res_we, 0);
    check({tag, ".addr"}, res_addr, 0);
  endtask

  // Expected trace from cycle 1 (LOAD) through one idle cycle after DONE.
  // Terms of output n are all (x,y) with x+y=n, enumerated by ascending y.
  task automatic build(input int sx, input int sy, input int ini);
    exp_t e;
    q.delete();
    e = '{busy: 1, done: 0, mac_en: 0, mac_clr: 0, we: 0, x: 0, y: 0, addr: 0};
    q.push_back(e);
    if (sx > 0 && sy > 0) begin
      for (int n = 0; n < sx + sy - 1; n++) begin
        bit first = 1;
        for (int y = 0; y < sy; y++) begin
          int x = n - y;
          if (x >= 0 && x < sx) begin
            e = '{busy: 1, done: 0, mac_en: 1, mac_clr: first, we: 0, x: x, y: y, addr: 0};
            q.push_back(e);
            first = 0;
          end
        end
        e = '{busy: 1, done: 0, mac_en: 0, mac_clr: 0, we: 0, x: 0, y: 0, addr: 0};
`ifdef CONV_SAME_MODE_EN
        e.we   = (n >= ini) && (n < ini + sx);
        e.addr = n - ini;
`else
        e.we   = 1;
        e.addr = n;
`endif
        q.push_back(e);
      end
    end
    e = '{busy: 1, done: 1, mac_en: 0, mac_clr: 0, we: 0, x: 0, y: 0, addr: 0};
    q.push_back(e);
    e = '{busy: 0, done: 0, mac_en: 0, mac_clr: 0, we: 0, x: 0, y: 0, addr: 0};
    q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE.
  task automatic run_job(input int sx, input int sy, input int ini, input string name);
    int macs = 0, writes = 0, exp_writes = 0, done_cyc = -1, exp_done;
    build(sx, sy, ini);
    size_x = sx[4:0];
    size_y = sy[4:0];
    init   = ini[5:0];
    start  = 1'b1;
    @(negedge clk);
    for (int k = 0; k < q.size(); k++) begin
      string t;
      t = $sformatf("%s.c%0d", name, k + 1);
      check({t, ".busy"}, busy, q[k].busy);
      check({t, ".done"}, done, q[k].done);
      check({t, ".mac_en"}, mac_en, q[k].mac_en);
      check({t, ".we"}, res_we, q[k].we);
      if (q[k].mac_en) begin
        check({t, ".clr"}, mac_clr, q[k].mac_clr);
        check({t, ".x"}, memx_addr, q[k].x);
        check({t, ".y"}, memy_addr, q[k].y);
      end
      if (q[k].we) begin
        check({t, ".addr"}, res_addr, q[k].addr);
        exp_writes++;
      end
      if (mac_en === 1'b1) macs++;
      if (res_we === 1'b1) writes++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = k + 1;
      // Hold the job inputs through LOAD, then scramble them (including stray start pulses) while busy.
      if (k == 0) begin
        start = 1'b0;
      end else if (k < q.size() - 1) begin
        start  = ($urandom_range(0, 3) == 0);
        size_x = 5'($urandom);
        size_y = 5'($urandom);
        init   = 6'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k < q.size() - 1) @(negedge clk);
    end
    exp_done = (sx == 0 || sy == 0) ? 2 : 2 + sx * sy + (sx + sy - 1);
    check({name, ".mac_count"}, macs, sx * sy);
    check({name, ".write_count"}, writes, exp_writes);
    check({name, ".done_cycle"}, done_cyc, exp_done);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    run_job(3, 2, 1, "j3x2");
    run_job(0, 5, 2, "j0x5");
    run_job(5, 0, 0, "j5x0");
    run_job(1, 1, 0, "j1x1");
    run_job(31, 31, 14, "j31x31");
    run_job(4, 7, 3, "j4x7");

    for (int r = 0; r < 6; r++) begin
      run_job($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 20),
              $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a 3x2 job, then a clean rerun.
    size_x = 5'd3;
    size_y = 5'd2;
    init   = 6'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid.mac_before_reset", mac_en, 1);
    rstn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("after_release");
    run_job(3, 2, 1, "rerun3x2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_seq_same.md
# conv_seq_same

Central convolution sequencer for the 1-D convolution core. It walks every full-convolution output index `n` and issues X/Y operand memory addresses with MAC control for each term. It then writes the accumulated result to the result memory. It sits directly downstream of the init-offset logic: it consumes the 6-bit same-window start offset computed from `size_y` and uses it to keep only the centred `size_x` outputs.

## Interface
Parameters: none (widths fixed: sizes 5 bits, output index 6 bits).

- `clk_i`  in  1  system clock, rising edge
- `rstn_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  start request; sampled only in IDLE
- `size_x_i`  in  5  length of X operand (0..31)
- `size_y_i`  in  5  length of Y operand (0..31)
- `init_i`  in  6  same-window start index from the init-offset stage
- `busy_o`  out  1  high in LOAD, MAC, WRITE, DONE
- `done_o`  out  1  one-cycle pulse in DONE
- `memx_addr_o`  out  5  X memory read address
- `memy_addr_o`  out  5  Y memory read address
- `mac_en_o`  out  1  address pair valid this cycle; accumulate
- `mac_clr_o`  out  1  first term of current output; accumulator loads instead of adds
- `res_we_o`  out  1  result memory write enable
- `res_addr_o`  out  6  result memory write address

## Operation
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE -> LOAD when `start_i`=1. In all other states `start_i` is ignored.
- LOAD (1 cycle):
  - Latch `size_x_i`, `size_y_i` and `init_i`; set `n`=0.
  - Compute `L` = sx+sy-1 (6-bit).
  - If sx=0 or sy=0, go to DONE directly; no MAC or write activity occurs.
- Per output `n`:
  - `jlo` = (n ≥ sx-1) ? n-(sx-1) : 0
  - `jhi` = min(n, sy-1)
  - All arithmetic is unsigned 6-bit; no overflow occurs for sizes ≤31.
- MAC state, one term per cycle, `j` from `jlo` up to `jhi`:
  - `memy_addr_o`=j, `memx_addr_o`=n-j, `mac_en_o`=1.
  - `mac_clr_o`=1 only when j=`jlo`.
  - On j=`jhi`, go to WRITE.
- WRITE (1 cycle):
  - Assert `res_we_o` if `n` is inside the write window (see Configuration).
  - Increment `n`.
  - If the old `n` = L-1, go to DONE; else go to MAC with j=new `jlo`.
- DONE (1 cycle): `done_o`=1, then return to IDLE.
- Input changes after LOAD have no effect on the running job.
- Reset (any state, including mid-run) forces IDLE. All outputs go to 0 and `n`/`j` clear. No partial write completes.

## Timing
- Reset value of every output: 0.
- Cycle 0 is the edge where `start_i` is sampled in IDLE:
  - LOAD is cycle 1.
  - MAC/WRITE occupy cycles 2 .. 1+sx·sy+L.
  - DONE is cycle 2+sx·sy+L.
  - For zero-size jobs, DONE is cycle 2.
- Operand memories have 1-cycle read latency. The MAC datapath aligns by delaying `mac_en_o`/`mac_clr_o` one cycle.
- WRITE follows the last MAC cycle by one cycle, so the accumulator has its final value when `res_we_o` is high.
- All outputs are registered (Moore, driven from state/counters), with no combinational input-to-output path.

## Configuration
Macro `CONV_SAME_MODE_EN`:
- Defined:
  - `res_we_o` is high in WRITE only when init ≤ n < init+sx.
  - `res_addr_o` = n-init, so exactly sx results are written at addresses 0..sx-1.
  - If init+sx > L, only indices up to L-1 are written; there is no wrap.
- Undefined (full mode):
  - `init_i` is ignored.
  - `res_we_o` is high in every WRITE, with `res_addr_o`=n, giving L results.
- FSM and MAC timing are identical in both builds.

## Test plan
- Same build, sx=3, sy=2, init=1, start pulse:
  - L=4; MAC pairs (x,y) = (0,0) | (1,0),(0,1) | (2,0),(1,1) | (2,1).
  - Writes at n=1,2,3 to addresses 0,1,2.
  - `done_o` in cycle 12.
- Full build, same stimulus: four writes at addresses 0..3; `done_o` in cycle 12.
- sx=0, sy=5: no `mac_en_o`/`res_we_o`; `busy_o` high for cycles 1–2; `done_o` in cycle 2.
- sx=1, sy=1, init=0: one MAC with `mac_clr_o`=1 at (0,0); one write at address 0; `done_o` in cycle 4.
- sx=31, sy=31: 61 outputs, MAC count 961; `done_o` in cycle 1024.
  - Same build, init=14: writes at addresses 0..30 only; no address exceeds 6 bits.
- `start_i` pulsed while busy: ignored.
- `rstn_i` low during MAC of the 3×2 job: all outputs 0 immediately; IDLE after release; a new start produces the full clean sequence.
